btn_evt_ctrl: RTL

BTN_EVT_CTRL -- requirements
Module: btn_evt_ctrl

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_evt_ctrl_if.sv | 14 +
 rtl/btn_deb_core.sv | 66 ++++++
 rtl/btn_evt_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared defaults and width helpers for the button event controller.
package btn_pkg;

    localparam int unsigned N_KEY_DEF         = 5;
    localparam int unsigned TICK_MAX_DEF      = 100000;
    localparam int unsigned STABLE_TICKS_DEF  = 10;
    localparam int unsigned REPEAT_DELAY_DEF  = 500;
    localparam int unsigned REPEAT_PERIOD_DEF = 100;

    // Stable counter holds 0..254, enough for STABLE_TICKS up to 255.
    localparam int unsigned STABLE_W = 8;

    function automatic int unsigned key_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

    // Width of a counter that runs over 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? unsigned'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/btn_evt_ctrl_if.sv
// Key-event handshake between the button controller and its consumer.
interface btn_evt_ctrl_if
    import btn_pkg::*;
#(
    parameter int unsigned N_KEY = N_KEY_DEF
);
    logic                      evt_valid;
    logic [key_w(N_KEY)-1:0]   evt_key;
    logic                      evt_ready;
    logic                      ovf;

    modport master (output evt_valid, output evt_key, output ovf, input evt_ready);
    modport slave  (input evt_valid, input evt_key, input ovf, output evt_ready);
endinterface

// File: rtl/btn_deb_core.sv
// One-key debouncer: 2-flop synchronizer, tick-sampled stable counter, level and edge pulses.
module btn_deb_core
    import btn_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    input  logic tick,
    output logic level,
    output logic press,
    output logic rel,
    output logic press_c
);
    logic                s1_q, s2_q;
    logic [STABLE_W-1:0] cnt_q, cnt_d;
    logic                level_q, level_d;
    logic                press_q, press_d;
    logic                rel_q, rel_d;
    logic                flip_c;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        flip_c  = 1'b0;
        if (tick) begin
            if (s2_q != level_q) begin
                if (cnt_q + STABLE_W'(1) == STABLE_W'(STABLE_TICKS)) begin
                    flip_c  = 1'b1;
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + STABLE_W'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
        press_d = flip_c & ~level_q;
        rel_d   = flip_c & level_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            s1_q    <= btn;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level   = level_q;
    assign press   = press_q;
    assign rel     = rel_q;
    assign press_c = press_d;
endmodule

// File: rtl/btn_evt_ctrl.sv
// Debounced multi-key controller with a pending-press queue and fixed-priority event handshake.
// Define BTN_REPEAT_EN to add auto-repeat events while a key is held.
module btn_evt_ctrl
    import btn_pkg::*;
#(
    parameter int unsigned N_KEY         = N_KEY_DEF,
    parameter int unsigned TICK_MAX      = TICK_MAX_DEF,
    parameter int unsigned STABLE_TICKS  = STABLE_TICKS_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_KEY-1:0] btn,
    output logic [N_KEY-1:0] level,
    output logic [N_KEY-1:0] press,
    output logic [N_KEY-1:0] rel,
    btn_evt_ctrl_if.master   evt
);
    localparam int unsigned KW = key_w(N_KEY);
    localparam int unsigned TW = cnt_w(TICK_MAX);

    if (N_KEY < 1 || N_KEY > 16 || TICK_MAX < 1 || STABLE_TICKS < 1 || STABLE_TICKS > 255 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_evt_ctrl: illegal parameter value");
    end

    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tick_c;
    logic [N_KEY-1:0] press_c, rpt_set_c, set_c, clr_c;
    logic [N_KEY-1:0] pending_q, pending_d;
    logic             evt_valid_q, evt_valid_d;
    logic [KW-1:0]    evt_key_q, evt_key_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        tick_c = (tcnt_q == TW'(TICK_MAX - 1));
        tcnt_d = tick_c ? '0 : tcnt_q + TW'(1);
    end

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        btn_deb_core #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
            .clk     (clk),
            .rstn    (rstn),
            .btn     (btn[k]),
            .tick    (tick_c),
            .level   (level[k]),
            .press   (press[k]),
            .rel     (rel[k]),
            .press_c (press_c[k])
        );
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = cnt_w(RMAX + 1);

    logic [N_KEY-1:0][RW-1:0] rcnt_q, rcnt_d;
    logic [N_KEY-1:0]         rper_q, rper_d;

    // Tick counter restarts at each press; first target is the delay, then the period.
    always_comb begin
        rcnt_d    = rcnt_q;
        rper_d    = rper_q;
        rpt_set_c = '0;
        for (int k = 0; k < int'(N_KEY); k++) begin
            if (!level[k]) begin
                rcnt_d[k] = '0;
                rper_d[k] = 1'b0;
            end else if (tick_c) begin
                if (rcnt_q[k] + RW'(1) == (rper_q[k] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
                    rpt_set_c[k] = 1'b1;
                    rcnt_d[k]    = '0;
                    rper_d[k]    = 1'b1;
                end else begin
                    rcnt_d[k] = rcnt_q[k] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rcnt_q <= '0;
            rper_q <= '0;
        end else begin
            rcnt_q <= rcnt_d;
            rper_q <= rper_d;
        end
    end
`else
    assign rpt_set_c = '0;
`endif

    // Pending set beats a same-edge accept; setting an already-pending key is a merge.
    always_comb begin
        set_c       = press_c | rpt_set_c;
        clr_c       = (evt_valid_q && evt.evt_ready) ? (N_KEY'(1) << evt_key_q) : '0;
        pending_d   = (pending_q & ~clr_c) | set_c;
        ovf_d       = ovf_q | (|(set_c & pending_q & ~clr_c));
        evt_valid_d = |pending_d;
        evt_key_d   = '0;
        for (int k = int'(N_KEY) - 1; k >= 0; k--) begin
            if (pending_d[k]) evt_key_d = KW'(k);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt_q      <= '0;
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            tcnt_q      <= tcnt_d;
            pending_q   <= pending_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            ovf_q       <= ovf_d;
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_key   = evt_key_q;
    assign evt.ovf       = ovf_q;
endmodule
